// File: rtl/flash_stream_reader.sv
// Streams bytes out of a CFI NOR flash (byte mode) through a first-word-fall-through
// FIFO to a valid/ready byte consumer. Flash is read only; WE# is held high.
module flash_stream_reader #(
  parameter logic [21:0] START_ADDR = 22'h000000,
  parameter logic [21:0] END_ADDR   = 22'h3FFFFF,
  parameter int          ACCESS_CYC = 5,
  parameter int          RST_CYC    = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [21:0] flash_addr,
  input  logic [7:0]  flash_data,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_rst_n,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  fifo_level,
  output logic        done,
  output logic [2:0]  dbg_state
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int WCW = $clog2(ACCESS_CYC + 1);
  localparam logic [4:0]     DEPTH_L  = 5'(FIFO_DEPTH);
  localparam logic [4:0]     DEPTH_M1 = 5'(FIFO_DEPTH - 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [WCW-1:0] WAIT_LD  = WCW'(ACCESS_CYC - 1);

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_RECOVER  = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t         state;
  logic [RCW-1:0] rcnt;
  logic [WCW-1:0] wcnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    level;
  logic          push;
  logic          pop;
  logic          cap_room;

  // Handshake: a byte moves on any clock edge where out_valid and out_ready are both
  // high; out_valid/out_data are held stable until that edge.
  assign out_valid  = (level != 5'd0);
  assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop        = out_valid & out_ready;
  assign push       = (state == S_CAPTURE);
  assign fifo_level = level;
  assign flash_we_n = 1'b1;
  assign dbg_state  = state;

  // The read launched at capture lands ACCESS_CYC+1 cycles later, so it must still
  // have a slot after this cycle's push (a simultaneous pop frees one).
  assign cap_room = pop | (level < DEPTH_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RST_HOLD;
      rcnt        <= '0;
      wcnt        <= '0;
      flash_addr  <= START_ADDR;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      flash_rst_n <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_RST_HOLD: begin
          if (rcnt == RST_LAST) begin
            rcnt        <= '0;
            flash_rst_n <= 1'b1;
            state       <= S_RECOVER;
          end else begin
            rcnt <= rcnt + RCW'(1);
          end
        end
        S_RECOVER: begin
          // FIFO is empty here, so the first read launches as recovery ends.
          if (rcnt == RST_LAST) begin
            rcnt       <= '0;
            flash_ce_n <= 1'b0;
            flash_oe_n <= 1'b0;
            wcnt       <= WAIT_LD;
            state      <= S_WAIT;
          end else begin
            rcnt <= rcnt + RCW'(1);
          end
        end
        S_ISSUE: begin
          if (level < DEPTH_L) begin
            flash_ce_n <= 1'b0;
            flash_oe_n <= 1'b0;
            wcnt       <= WAIT_LD;
            state      <= S_WAIT;
          end else begin
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            wcnt <= wcnt - WCW'(1);
          end
        end
        S_CAPTURE: begin
          if (flash_addr == END_ADDR) begin
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            state      <= S_FINISH;
          end else begin
            flash_addr <= flash_addr + 22'd1;
            if (cap_room) begin
              // Back-to-back read: strobes stay low, next address launches now.
              wcnt  <= WAIT_LD;
              state <= S_WAIT;
            end else begin
              flash_ce_n <= 1'b1;
              flash_oe_n <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_FINISH: begin
          if (pop && (level == 5'd1)) begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_RST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= flash_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

endmodule
